// File: rtl/control_ascensor_pkg.sv
// rtl/control_ascensor_pkg.sv - shared types, request codes and decode for the elevator controller
//
// Package pkg_ascensor
//   estado_t     : controller FSM states
//   CABINA_*/P*  : request codes returned by the request-memory stage
//   QUIETO/SUBE/BAJA : accion_m encodings
//   decodificar  : request code -> target floor plus valid flag
package pkg_ascensor;

  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    CONSULTA = 3'd1,
    EVALUA   = 3'd2,
    VIAJE    = 3'd3,
    ABRIR    = 3'd4,
    PUERTA   = 3'd5
  } estado_t;

  localparam logic [3:0] CABINA_1 = 4'd1;
  localparam logic [3:0] CABINA_2 = 4'd2;
  localparam logic [3:0] CABINA_3 = 4'd3;
  localparam logic [3:0] CABINA_4 = 4'd4;
  localparam logic [3:0] P1_SUBE  = 4'd5;
  localparam logic [3:0] P2_BAJA  = 4'd6;
  localparam logic [3:0] P2_SUBE  = 4'd7;
  localparam logic [3:0] P3_BAJA  = 4'd8;
  localparam logic [3:0] P3_SUBE  = 4'd9;
  localparam logic [3:0] P4_BAJA  = 4'd10;

  localparam logic [1:0] QUIETO = 2'd0;
  localparam logic [1:0] SUBE   = 2'd1;
  localparam logic [1:0] BAJA   = 2'd2;

  typedef struct packed {
    logic       valido;
    logic [1:0] piso;
  } destino_t;

  // Codes 0 and 11..15 carry no request.
  function automatic destino_t decodificar(input logic [3:0] codigo);
    destino_t d;
    d.valido = 1'b1;
    d.piso   = 2'd0;
    case (codigo)
      CABINA_1, P1_SUBE:          d.piso = 2'd0;
      CABINA_2, P2_BAJA, P2_SUBE: d.piso = 2'd1;
      CABINA_3, P3_BAJA, P3_SUBE: d.piso = 2'd2;
      CABINA_4, P4_BAJA:          d.piso = 2'd3;
      default:                    d.valido = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/control_ascensor_temporizador.sv
// rtl/control_ascensor_temporizador.sv - loadable down-counter shared by all controller states
//
// Ports
//   i_clk, i_reset : clock, asynchronous active-high reset (loads VALOR_RESET)
//   i_cargar       : load i_valor this cycle (takes priority over counting)
//   i_valor        : value to load; callers pass (dwell - 1)
//   o_cero         : count has reached zero
module temporizador import pkg_ascensor::*; #(
  parameter int                 ANCHO_T     = 28,
  parameter logic [ANCHO_T-1:0] VALOR_RESET = '0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_cargar,
  input  logic [ANCHO_T-1:0] i_valor,
  output logic               o_cero
);

  logic [ANCHO_T-1:0] r_cuenta;

  // Holds at zero so a state that ignores o_cero never sees a wrap.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cuenta <= VALOR_RESET;
    end else if (i_cargar) begin
      r_cuenta <= i_valor;
    end else if (r_cuenta != '0) begin
      r_cuenta <= r_cuenta - ANCHO_T'(1);
    end
  end

  assign o_cero = (r_cuenta == '0);

endmodule

// File: rtl/control_ascensor.sv
// rtl/control_ascensor.sv - elevator motion/door controller driven by the request-memory stage
//
// Ports
//   clk, reset      : clock, asynchronous active-high reset
//   nueva_solicitud : button stored upstream; forces an immediate query from REPOSO
//   memoria         : request code from request memory, sampled at the end of the obtener pulse
//   obtener         : one-cycle fetch pulse to request memory
//   accion_m        : 0 stopped, 1 up, 2 down
//   piso_m          : current floor 0..3
//   puertas_m       : doors open
//   motor_subir/bajar : motor drive, only while travelling
module control_ascensor import pkg_ascensor::*; #(
  parameter int T_VIAJE  = 50_000_000,
  parameter int T_PUERTA = 150_000_000,
  parameter int T_SONDEO = 1_000,
  parameter int ANCHO_T  = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nueva_solicitud,
  input  logic [3:0] memoria,
  output logic       obtener,
  output logic [1:0] accion_m,
  output logic [1:0] piso_m,
  output logic       puertas_m,
  output logic       motor_subir,
  output logic       motor_bajar
);

  // The counter expires at zero, so a dwell of N cycles loads N-1.
  localparam logic [ANCHO_T-1:0] C_VIAJE  = ANCHO_T'(T_VIAJE - 1);
  localparam logic [ANCHO_T-1:0] C_PUERTA = ANCHO_T'(T_PUERTA - 1);
  localparam logic [ANCHO_T-1:0] C_SONDEO = ANCHO_T'(T_SONDEO - 1);

  estado_t            r_estado;
  logic [3:0]         r_codigo;
  logic               r_obtener;
  logic [1:0]         r_accion;
  logic [1:0]         r_piso;
  logic               r_puertas;
  logic               r_subir;
  logic               r_bajar;

  logic               w_cargar;
  logic [ANCHO_T-1:0] w_valor_carga;
  logic               w_cero;
  destino_t           w_dest;

  assign w_dest = decodificar(r_codigo);

  // Every dwell starts from EVALUA: poll interval, door dwell (which covers
  // ABRIR plus PUERTA) or one floor of travel.
  always_comb begin
    w_cargar      = 1'b0;
    w_valor_carga = C_SONDEO;
    if (r_estado == EVALUA) begin
      w_cargar = 1'b1;
      if (!w_dest.valido) begin
        w_valor_carga = C_SONDEO;
      end else if (w_dest.piso == r_piso) begin
        w_valor_carga = C_PUERTA;
      end else begin
        w_valor_carga = C_VIAJE;
      end
    end
  end

  temporizador #(
    .ANCHO_T     (ANCHO_T),
    .VALOR_RESET (C_SONDEO)
  ) u_temporizador (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_cargar (w_cargar),
    .i_valor  (w_valor_carga),
    .o_cero   (w_cero)
  );

  // obtener is registered: it is raised on every edge entering CONSULTA or
  // ABRIR and dropped on the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado  <= REPOSO;
      r_codigo  <= 4'd0;
      r_obtener <= 1'b0;
      r_accion  <= QUIETO;
      r_piso    <= 2'd0;
      r_puertas <= 1'b0;
      r_subir   <= 1'b0;
      r_bajar   <= 1'b0;
    end else begin
      r_obtener <= 1'b0;
      case (r_estado)
        REPOSO: begin
          if (nueva_solicitud || w_cero) begin
            r_obtener <= 1'b1;
            r_estado  <= CONSULTA;
          end
        end
        CONSULTA: begin
          r_codigo <= memoria;
          r_estado <= EVALUA;
        end
        EVALUA: begin
          if (!w_dest.valido) begin
            r_accion <= QUIETO;
            r_estado <= REPOSO;
          end else if (w_dest.piso == r_piso) begin
            r_accion  <= QUIETO;
            r_puertas <= 1'b1;
            r_obtener <= 1'b1;
            r_estado  <= ABRIR;
          end else if (w_dest.piso > r_piso) begin
            r_accion <= SUBE;
            r_subir  <= 1'b1;
            r_estado <= VIAJE;
          end else begin
            r_accion <= BAJA;
            r_bajar  <= 1'b1;
            r_estado <= VIAJE;
          end
        end
        VIAJE: begin
          if (w_cero) begin
            // accion_m stays set into CONSULTA so the memory stage answers
            // with the stop request for the floor just reached.
            if (r_accion == SUBE) begin
              if (r_piso == 2'd3) r_accion <= QUIETO;
              else                r_piso   <= r_piso + 2'd1;
            end else if (r_accion == BAJA) begin
              if (r_piso == 2'd0) r_accion <= QUIETO;
              else                r_piso   <= r_piso - 2'd1;
            end
            r_subir   <= 1'b0;
            r_bajar   <= 1'b0;
            r_obtener <= 1'b1;
            r_estado  <= CONSULTA;
          end
        end
        ABRIR: begin
          // The fetch issued on entry only clears same-floor codes upstream;
          // its response is never sampled.
          r_estado <= PUERTA;
        end
        PUERTA: begin
          if (w_cero) begin
            r_puertas <= 1'b0;
            r_obtener <= 1'b1;
            r_estado  <= CONSULTA;
          end
        end
        default: r_estado <= REPOSO;
      endcase
    end
  end

  assign obtener     = r_obtener;
  assign accion_m    = r_accion;
  assign piso_m      = r_piso;
  assign puertas_m   = r_puertas;
  assign motor_subir = r_subir;
  assign motor_bajar = r_bajar;

endmodule
